// File: rtl/banked_sram.sv
// Multi-bank synchronous SRAM with byte-lane writes, read-after-write forwarding,
// a one-entry CPU write buffer behind debug-write priority, and optional zero-fill.
module banked_sram #(
   parameter int unsigned DWIDTH         = 16,
   parameter int unsigned AWIDTH         = 16,
   parameter int unsigned BANK_AW        = 8,
   parameter int unsigned NBANKS         = 2,
   parameter logic [3:0]  REGION         = 4'h0,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AWIDTH-1:0]   rd_addr,
   input  logic                rd_en,
   output logic [DWIDTH-1:0]   rd_data,
   input  logic [AWIDTH-1:0]   cpu_waddr,
   input  logic [DWIDTH-1:0]   cpu_wdata,
   input  logic [DWIDTH/8-1:0] cpu_wmask,
   input  logic                cpu_we,
   output logic                cpu_wready,
   input  logic [AWIDTH-1:0]   dbg_waddr,
   input  logic [DWIDTH-1:0]   dbg_wdata,
   input  logic                dbg_we,
   output logic                busy
);

   localparam int unsigned Lanes = DWIDTH / 8;
   localparam int unsigned IdxW  = BANK_AW + $clog2(NBANKS);
   localparam int unsigned Words = 1 << BANK_AW;

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e               state_q, state_d;
   logic [BANK_AW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DWIDTH-1:0]    mem [NBANKS*Words];

   logic                 pend_valid_q, pend_valid_d;
   logic [AWIDTH-1:0]    pend_addr_q, pend_addr_d;
   logic [DWIDTH-1:0]    pend_data_q, pend_data_d;
   logic [Lanes-1:0]     pend_mask_q, pend_mask_d;

   logic                 wr_en, wr_commit;
   logic [AWIDTH-1:0]    wr_addr;
   logic [DWIDTH-1:0]    wr_data, wr_bits, rd_word;
   logic [Lanes-1:0]     wr_mask;
   logic [IdxW-1:0]      wr_idx, rd_idx;
   logic                 run;

   function automatic logic in_region(input logic [AWIDTH-1:0] a);
      return a[AWIDTH-1 -: 4] == REGION;
   endfunction

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? StClear : StRun;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == StClear) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == '1) state_d = StRun;
      end
   end

   // FSM: outputs
   always_comb begin
      run        = (state_q == StRun);
      busy       = (state_q == StClear);
      cpu_wready = run & ~pend_valid_q;
   end

   // Single commit port: debug first, then the buffered CPU write, then a live CPU write.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cpu_waddr;
      wr_data = cpu_wdata;
      wr_mask = cpu_wmask;
      if (run) begin
         if (dbg_we) begin
            wr_en   = 1'b1;
            wr_addr = dbg_waddr;
            wr_data = dbg_wdata;
            wr_mask = '1;
         end else if (pend_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr_q;
            wr_data = pend_data_q;
            wr_mask = pend_mask_q;
         end else if (cpu_we) begin
            wr_en = 1'b1;
         end
      end
      wr_commit = wr_en & in_region(wr_addr);
      wr_idx    = wr_addr[IdxW-1:0];
      for (int l = 0; l < Lanes; l++) wr_bits[8*l +: 8] = {8{wr_mask[l]}};
   end

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      pend_mask_d  = pend_mask_q;
      if (cpu_we && cpu_wready && dbg_we) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = cpu_waddr;
         pend_data_d  = cpu_wdata;
         pend_mask_d  = cpu_wmask;
      end else if (run && pend_valid_q && !dbg_we) begin
         pend_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         pend_mask_q  <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         pend_mask_q  <= pend_mask_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == StClear) begin
            for (int b = 0; b < NBANKS; b++) begin
               mem[IdxW'(b * Words + int'(clr_cnt_q))] <= '0;
            end
         end else if (wr_commit) begin
            for (int l = 0; l < Lanes; l++) begin
               if (wr_mask[l]) mem[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
         end
      end
   end

   // Forward the post-write word when the read hits the word committed this cycle.
   always_comb begin
      rd_idx  = rd_addr[IdxW-1:0];
      rd_word = mem[rd_idx];
      if (wr_commit && (wr_idx == rd_idx)) rd_word = (rd_word & ~wr_bits) | (wr_data & wr_bits);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (run && in_region(rd_addr)) ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_banked_sram.sv
// Directed bench for banked_sram at default parameters (2 banks x 256 x 16).
module tb_banked_sram;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rd_addr, rd_data, cpu_waddr, cpu_wdata, dbg_waddr, dbg_wdata;
   logic [1:0]  cpu_wmask;
   logic        rd_en, cpu_we, cpu_wready, dbg_we, busy;

   int vectors = 0;
   int miscompares = 0;
   int n;

   banked_sram dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .cpu_waddr  (cpu_waddr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wmask  (cpu_wmask),
      .cpu_we     (cpu_we),
      .cpu_wready (cpu_wready),
      .dbg_waddr  (dbg_waddr),
      .dbg_wdata  (dbg_wdata),
      .dbg_we     (dbg_we),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
      cpu_waddr = a;
      cpu_wdata = d;
      cpu_wmask = m;
      cpu_we    = 1'b1;
      tick();
      cpu_we    = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      check(tag, rd_data, exp);
   endtask

   task automatic count_busy(input string tag);
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      check(tag, n, 256);
      check({tag, "_wready"}, cpu_wready, 1'b1);
   endtask

   initial begin
      reset = 1'b1; rd_en = 1'b0; rd_addr = '0;
      cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0; cpu_wmask = '0;
      dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_busy", busy, 1'b1);
      check("reset_wready", cpu_wready, 1'b0);
      check("reset_rd_data", rd_data, 16'h0000);
      count_busy("clear_len");

      // Every word in both banks reads zero after the fill.
      rd_en = 1'b1;
      for (int i = 0; i < 512; i++) begin
         rd_addr = 16'(i);
         tick();
         check("zero_fill", rd_data, 16'h0000);
      end
      rd_en = 1'b0;

      cpu_write(16'h0005, 16'h5A5A, 2'b11);
      cpu_write(16'h0105, 16'hA5A5, 2'b11);
      read_check("rd_bank1", 16'h0105, 16'hA5A5);
      read_check("rd_bank0", 16'h0005, 16'h5A5A);
      read_check("rd_out_region", 16'h8005, 16'h0000);
      read_check("rd_bank1_again", 16'h0105, 16'hA5A5);
      tick(); tick();
      check("rd_hold", rd_data, 16'hA5A5);

      // Debug and CPU collide on 0x0010: debug lands first, buffered CPU write second.
      dbg_waddr = 16'h0010; dbg_wdata = 16'h1111; dbg_we = 1'b1;
      cpu_waddr = 16'h0010; cpu_wdata = 16'h2222; cpu_wmask = 2'b11; cpu_we = 1'b1;
      check("collide_wready", cpu_wready, 1'b1);
      tick();
      dbg_we = 1'b0; cpu_we = 1'b0;
      check("pending_wready", cpu_wready, 1'b0);
      rd_en = 1'b1; rd_addr = 16'h0010;
      tick();
      rd_en = 1'b0;
      check("pending_fwd", rd_data, 16'h2222);
      check("pending_done_wready", cpu_wready, 1'b1);
      read_check("collide_final", 16'h0010, 16'h2222);

      // Debug held for three more cycles keeps the CPU write buffered.
      dbg_waddr = 16'h0040; dbg_wdata = 16'h4444; dbg_we = 1'b1;
      cpu_waddr = 16'h0030; cpu_wdata = 16'h3333; cpu_wmask = 2'b11; cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         dbg_waddr = 16'h0041 + 16'(k);
         dbg_wdata = 16'h4100 + 16'(k);
         check("hold_wready", cpu_wready, 1'b0);
         tick();
      end
      dbg_we = 1'b0;
      check("hold_wready_last", cpu_wready, 1'b0);
      tick();
      check("hold_release", cpu_wready, 1'b1);
      read_check("hold_pending", 16'h0030, 16'h3333);
      read_check("hold_dbg0", 16'h0040, 16'h4444);
      read_check("hold_dbg3", 16'h0043, 16'h4102);
      cpu_write(16'h0030, 16'h5555, 2'b11);
      read_check("order", 16'h0030, 16'h5555);

      // Low-lane write with same-cycle read returns the merged word.
      cpu_write(16'h0020, 16'hABCD, 2'b11);
      cpu_waddr = 16'h0020; cpu_wdata = 16'h1234; cpu_wmask = 2'b01; cpu_we = 1'b1;
      rd_en = 1'b1; rd_addr = 16'h0020;
      tick();
      cpu_we = 1'b0; rd_en = 1'b0;
      check("mask_fwd", rd_data, 16'hAB34);
      cpu_write(16'h0020, 16'hFFFF, 2'b00);
      read_check("mask_zero", 16'h0020, 16'hAB34);
      cpu_write(16'h0020, 16'h99EE, 2'b10);
      read_check("mask_hi", 16'h0020, 16'h9934);
      cpu_write(16'h8020, 16'h7777, 2'b11);
      dbg_waddr = 16'h9020; dbg_wdata = 16'h6666; dbg_we = 1'b1;
      tick();
      dbg_we = 1'b0;
      read_check("out_region_wr", 16'h0020, 16'h9934);

      dbg_waddr = 16'h0050; dbg_wdata = 16'hBEEF; dbg_we = 1'b1;
      rd_en = 1'b1; rd_addr = 16'h0050;
      tick();
      dbg_we = 1'b0; rd_en = 1'b0;
      check("dbg_fwd", rd_data, 16'hBEEF);

      // Reset with a buffered write and non-zero rd_data, then again mid-fill.
      dbg_waddr = 16'h0060; dbg_wdata = 16'h6666; dbg_we = 1'b1;
      cpu_waddr = 16'h0061; cpu_wdata = 16'h7777; cpu_wmask = 2'b11; cpu_we = 1'b1;
      tick();
      dbg_we = 1'b0; cpu_we = 1'b0;
      check("pre_reset_pending", cpu_wready, 1'b0);
      reset = 1'b1;
      tick();
      check("rst_rd_data", rd_data, 16'h0000);
      check("rst_busy", busy, 1'b1);
      check("rst_wready", cpu_wready, 1'b0);
      reset = 1'b0;
      repeat (100) tick();
      check("mid_clear_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      count_busy("restart_len");
      read_check("after_clear_pend", 16'h0061, 16'h0000);
      read_check("after_clear_b1", 16'h0105, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
